// File: rtl/hs4_rx_fifo.sv
// hs4_rx_fifo: receive stage for a 4-phase bundled-data handshake.
// The request is synchronised into the clk domain. A two-state FSM captures
// one token per handshake into a small first-word-fall-through FIFO, and the
// buffered tokens are offered to clocked logic over a valid/ready interface.

module hs4_rx_fifo #(
    parameter int DW          = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_in,
    input  logic [DW-1:0]                data_in,
    output logic                         ack_out,
    output logic [DW-1:0]                dout,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [DW-1:0]          mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   push;
    logic                   pop;
    logic [CW-1:0]          count_next;

    assign req_s      = sync_q[SYNC_STAGES-1];
    assign dout_valid = (count != '0);
    assign dout       = mem[rd_ptr];
    assign pop        = dout_valid & dout_ready;
    // The registered full flag gates the write, so a pop on a stalled cycle
    // only frees the slot for the following edge.
    assign push       = (state == IDLE) & req_s & ~full;

    // Occupancy moves only when exactly one of push/pop happens
    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Multi-flop synchroniser for the asynchronous request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    // Handshake FSM; ack_out is registered and tracks the ACKED state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ack_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (push) begin
                        state   <= ACKED;
                        ack_out <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!req_s) begin
                        state   <= IDLE;
                        ack_out <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ack_out <= 1'b0;
                end
            endcase
        end
    end

    // Token storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy counter with a registered full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            full  <= 1'b0;
        end else begin
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_hs4_rx_fifo.sv
// tb_hs4_rx_fifo: directed scenarios plus a randomized phase. The model is
// a token queue with the request seen SYNC_STAGES edges late.

module tb_hs4_rx_fifo;

    localparam int DW          = 8;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] count;
    logic          full;

    int checks = 0;
    int bad    = 0;

    logic [DW-1:0] mq[$];
    logic          reqPipe[$];
    logic          mAck;
    logic [DW-1:0] gotQ[$];
    bit            recordPops;

    hs4_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_in     (req_in),
        .data_in    (data_in),
        .ack_out    (ack_out),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .count      (count),
        .full       (full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        reqPipe.delete();
        for (int i = 0; i < SYNC_STAGES; i++) reqPipe.push_back(1'b0);
        mAck = 1'b0;
    endtask

    // One clock edge of the reference: request seen late, one token per handshake
    task automatic modelEdge();
        logic reqS;
        bit   popNow;
        bit   pushNow;
        reqS    = reqPipe.pop_front();
        reqPipe.push_back(req_in);
        popNow  = (mq.size() != 0) && dout_ready;
        pushNow = !mAck && reqS && (mq.size() < DEPTH);
        if (mAck && !reqS) mAck = 1'b0;
        else if (pushNow)  mAck = 1'b1;
        if (popNow)  void'(mq.pop_front());
        if (pushNow) mq.push_back(data_in);
    endtask

    task automatic compareAll();
        checkOutput("ack", ack_out, mAck);
        checkOutput("valid", dout_valid, mq.size() != 0);
        checkOutput("count", count, mq.size());
        checkOutput("full", full, mq.size() == DEPTH);
        if (mq.size() != 0) checkOutput("dout", dout, mq[0]);
    endtask

    task automatic applyStimulus();
        if (recordPops && dout_valid && dout_ready) gotQ.push_back(dout);
        @(posedge clk);
        modelEdge();
        #1;
        compareAll();
    endtask

    task automatic waitAck(input logic level);
        for (int i = 0; i < 30 && mAck != level; i++) applyStimulus();
        if (mAck != level) checkOutput("hs_timeout", mAck, level);
    endtask

    task automatic sendToken(input logic [DW-1:0] d);
        req_in  = 1'b1;
        data_in = d;
        waitAck(1'b1);
        req_in = 1'b0;
        waitAck(1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_in     = 1'b0;
        data_in    = '0;
        dout_ready = 1'b0;
        recordPops = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_ack", ack_out, 0);
        checkOutput("rst_valid", dout_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_full", full, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single token: ack three edges after the request
        req_in  = 1'b1;
        data_in = 8'hA5;
        applyStimulus();
        applyStimulus();
        checkOutput("t1_ack_early", ack_out, 0);
        applyStimulus();
        checkOutput("t1_ack", ack_out, 1);
        checkOutput("t1_dout", dout, 8'hA5);
        checkOutput("t1_count", count, 1);
        req_in = 1'b0;
        waitAck(1'b0);
        dout_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("empty_ready_count", count, 0);
        checkOutput("empty_ready_valid", dout_valid, 0);
        dout_ready = 1'b0;

        // Fill, stall the fifth request, release it with a single pop
        for (int i = 1; i <= 4; i++) sendToken(DW'(i));
        checkOutput("t2_full", full, 1);
        checkOutput("t2_count", count, 4);
        req_in  = 1'b1;
        data_in = 8'h05;
        repeat (6) applyStimulus();
        checkOutput("t2_ack_held", ack_out, 0);
        dout_ready = 1'b1;
        applyStimulus();
        dout_ready = 1'b0;
        checkOutput("t2_ack_after_pop", ack_out, 0);
        applyStimulus();
        checkOutput("t2_ack_late", ack_out, 1);
        checkOutput("t2_count_late", count, 4);
        req_in = 1'b0;
        waitAck(1'b0);
        dout_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            checkOutput("t2_drain", dout, i);
            applyStimulus();
        end
        checkOutput("t2_empty", dout_valid, 0);
        dout_ready = 1'b0;

        // Wrap with the consumer always ready
        gotQ.delete();
        recordPops = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_in  = 1'b1;
            data_in = DW'(i);
            for (int c = 0; c < 30 && !mAck; c++) begin
                applyStimulus();
                checkOutput("t3_count_le1", count <= 1, 1);
            end
            req_in = 1'b0;
            for (int c = 0; c < 30 && mAck; c++) begin
                applyStimulus();
                checkOutput("t3_count_le1", count <= 1, 1);
            end
        end
        repeat (2) applyStimulus();
        recordPops = 1'b0;
        checkOutput("t3_popped", gotQ.size(), 10);
        for (int i = 0; i < gotQ.size() && i < 10; i++) checkOutput("t3_order", gotQ[i], i);
        dout_ready = 1'b0;

        // Simultaneous push and pop at count one
        sendToken(8'h11);
        req_in  = 1'b1;
        data_in = 8'h22;
        applyStimulus();
        applyStimulus();
        dout_ready = 1'b1;
        applyStimulus();
        dout_ready = 1'b0;
        checkOutput("t4_count", count, 1);
        checkOutput("t4_dout", dout, 8'h22);
        req_in = 1'b0;
        waitAck(1'b0);
        dout_ready = 1'b1;
        applyStimulus();
        dout_ready = 1'b0;

        // Reset while acknowledged with two tokens stored
        sendToken(8'h44);
        req_in  = 1'b1;
        data_in = 8'h55;
        repeat (3) applyStimulus();
        checkOutput("t5_ack_before", ack_out, 1);
        checkOutput("t5_count_before", count, 2);
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("t5_rst_ack", ack_out, 0);
        checkOutput("t5_rst_count", count, 0);
        checkOutput("t5_rst_valid", dout_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("t5_ack_wait", ack_out, 0);
        applyStimulus();
        checkOutput("t5_recapture", ack_out, 1);
        checkOutput("t5_count", count, 1);
        checkOutput("t5_dout", dout, 8'h55);
        req_in = 1'b0;
        waitAck(1'b0);

        // Randomized upstream and consumer against the reference model
        for (int c = 0; c < 1500; c++) begin
            dout_ready = ($urandom_range(0, 2) == 0);
            if (!req_in && !mAck && $urandom_range(0, 1) == 1) begin
                req_in  = 1'b1;
                data_in = DW'($urandom);
            end else if (req_in && mAck && $urandom_range(0, 2) != 0) begin
                req_in = 1'b0;
            end
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end

endmodule
